// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta DAC: double-buffered WIDTH-bit samples, each played out as a
// 2^WIDTH-cycle pulse-density frame whose ones-count equals the sample value.
module sigma_delta_dac #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             dac_out,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] count;
    logic             stop_pending;

    logic             do_load;
    logic             last_bit;
    logic             accept;
    logic [WIDTH:0]   sum;

    assign sample_ready = !hold_full;
    assign busy         = (state == RUN);
    assign accept       = sample_valid && !hold_full;
    assign last_bit     = (count == '1);
    assign sum          = {1'b0, acc} + {1'b0, cur};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A load happens on the start edge and on every frame boundary that does not exit.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    do_load    = 1'b1;
                end
            end
            RUN: begin
                if (last_bit) begin
                    if (stop_pending || stop) begin
                        state_next = IDLE;
                    end else begin
                        do_load = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold         <= '0;
            hold_full    <= 1'b0;
            cur          <= '0;
            acc          <= '0;
            count        <= '0;
            stop_pending <= 1'b0;
            dac_out      <= 1'b0;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;

            if (state == IDLE) begin
                dac_out      <= 1'b0;
                acc          <= '0;
                count        <= '0;
                stop_pending <= start && stop;
            end else begin
                acc     <= sum[WIDTH-1:0];
                dac_out <= sum[WIDTH];
                count   <= count + WIDTH'(1);
                if (stop) begin
                    stop_pending <= 1'b1;
                end
                if (last_bit) begin
                    frame_done <= 1'b1;
                end
            end

            // Load only empties a full register, accept only fills an empty one, so they never collide.
            if (do_load) begin
                if (hold_full) begin
                    cur       <= hold;
                    hold_full <= 1'b0;
                end else begin
                    cur      <= '0;
                    underrun <= 1'b1;
                end
            end

            if (accept) begin
                hold      <= sample_in;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Self-checking bench for sigma_delta_dac: frame-level behavioural model plus
// literal per-frame ones-count expectations for directed scenarios.
module tb_sigma_delta_dac;

    localparam int WIDTH = 8;
    localparam int N     = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [WIDTH-1:0] sample_in = '0;
    logic             sample_valid = 1'b0;
    logic             sample_ready;
    logic             dac_out;
    logic             busy;
    logic             frame_done;
    logic             underrun;

    sigma_delta_dac #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .dac_out      (dac_out),
        .busy         (busy),
        .frame_done   (frame_done),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails = 0;

    // Model state: whether a frame is playing, its cycle index, the sample it plays.
    int m_run = 0;
    int m_k = 0;
    int m_cur = 0;
    int m_hold = 0;
    int m_hold_full = 0;
    int m_pend = 0;
    int m_dac = 0;
    int m_fd = 0;
    int m_ur = 0;
    int accept_cnt = 0;
    int m_xfer;
    int m_old_pend;

    // Bit k of a frame of value s is the number of whole multiples of N crossed by the k-th add.
    function automatic int pulse_bit(int s, int k);
        return ((k + 1) * s) / N - (k * s) / N;
    endfunction

    task automatic model_load();
        if (m_hold_full != 0) begin
            m_cur       = m_hold;
            m_hold_full = 0;
        end else begin
            m_cur = 0;
            m_ur  = 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_k = 0; m_cur = 0; m_hold = 0; m_hold_full = 0;
            m_pend = 0; m_dac = 0; m_fd = 0; m_ur = 0;
        end else begin
            m_xfer = (sample_valid && m_hold_full == 0) ? 1 : 0;
            m_fd = 0;
            m_ur = 0;
            if (m_run == 0) begin
                m_dac = 0; m_k = 0; m_pend = 0;
                if (start) begin
                    m_run  = 1;
                    m_pend = stop ? 1 : 0;
                    model_load();
                end
            end else begin
                m_dac      = pulse_bit(m_cur, m_k);
                m_old_pend = m_pend;
                if (stop) m_pend = 1;
                if (m_k == N - 1) begin
                    m_k  = 0;
                    m_fd = 1;
                    if (m_old_pend != 0 || stop) m_run = 0;
                    else model_load();
                end else begin
                    m_k++;
                end
            end
            if (m_xfer != 0) begin
                m_hold      = int'(sample_in);
                m_hold_full = 1;
                accept_cnt++;
            end
        end
    end

    int exp_q[$];
    int frame_check_en = 0;
    int hist[N];
    int hist_idx = 0;
    int hist_sum = 0;
    int ur_seen = 0;

    task automatic check_output(string name, int actual, int expected);
        tests_run++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Every cycle: compare all outputs with the model and track the last N output bits.
    task automatic tick();
        @(negedge clk);
        check_output("dac_out", int'(dac_out), m_dac);
        check_output("busy", int'(busy), m_run);
        check_output("frame_done", int'(frame_done), m_fd);
        check_output("underrun", int'(underrun), m_ur);
        check_output("sample_ready", int'(sample_ready), (m_hold_full == 0) ? 1 : 0);
        hist_sum = hist_sum - hist[hist_idx] + int'(dac_out);
        hist[hist_idx] = int'(dac_out);
        hist_idx = (hist_idx + 1) % N;
        if (underrun) ur_seen++;
        if (frame_check_en != 0 && frame_done) begin
            if (exp_q.size() == 0) check_output("frame_unexpected", hist_sum, -1);
            else check_output("frame_ones", hist_sum, exp_q.pop_front());
        end
    endtask

    task automatic push_sample(int v);
        int c;
        int n;
        c = accept_cnt;
        n = 0;
        sample_valid = 1'b1;
        sample_in    = WIDTH'(v);
        while (accept_cnt == c && n < 2 * N + 10) begin
            tick();
            n++;
        end
        if (accept_cnt == c) check_output("push_timeout", int'(sample_ready), 1);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_start(logic with_stop);
        start = 1'b1;
        stop  = with_stop;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_idle(int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        if (busy) check_output("wait_idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_frame_done(int max);
        int n;
        n = 0;
        while (!frame_done && n < max) begin
            tick();
            n++;
        end
        if (!frame_done) check_output("frame_done_timeout", int'(frame_done), 1);
    endtask

    task automatic stop_one_cycle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic apply_stimulus();
        int base;
        int c0;
        int n;
        int frames;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_output("reset_ready", int'(sample_ready), 1);
        check_output("reset_busy", int'(busy), 0);

        // Quarter-scale sample with stop requested early in the only frame.
        frame_check_en = 1;
        exp_q = {64};
        ur_seen = 0;
        push_sample(8'h40);
        pulse_start(1'b0);
        repeat (10) tick();
        stop_one_cycle();
        wait_idle(2 * N);
        tick();
        check_output("a_underruns", ur_seen, 0);
        check_output("a_frames_left", exp_q.size(), 0);

        // Zero frame then full-scale frame; a start during RUN must be ignored.
        exp_q = {0, 255};
        push_sample(8'h00);
        pulse_start(1'b0);
        push_sample(8'hFF);
        repeat (5) tick();
        pulse_start(1'b0);
        wait_frame_done(2 * N);
        stop_one_cycle();
        wait_idle(2 * N);
        check_output("b_frames_left", exp_q.size(), 0);

        // Underrun on start, mid-frame push plays in the following frame.
        exp_q = {0, 128};
        ur_seen = 0;
        pulse_start(1'b0);
        repeat (50) tick();
        push_sample(8'h80);
        wait_frame_done(2 * N);
        stop_one_cycle();
        wait_idle(2 * N);
        check_output("c_underruns", ur_seen, 1);
        check_output("c_frames_left", exp_q.size(), 0);

        // Valid held high with incrementing data: one accept per frame.
        base = int'($urandom_range(0, 200));
        exp_q = {base, base + 1, base + 2, base + 3};
        c0 = accept_cnt;
        sample_valid = 1'b1;
        sample_in = WIDTH'(base);
        n = 0;
        while (accept_cnt == c0 && n < 10) begin
            tick();
            n++;
        end
        sample_in = WIDTH'(base + accept_cnt - c0);
        start = 1'b1;
        tick();
        start = 1'b0;
        sample_in = WIDTH'(base + accept_cnt - c0);
        frames = 0;
        n = 0;
        while (busy && n < 5 * N) begin
            tick();
            n++;
            sample_in = WIDTH'(base + accept_cnt - c0);
            if (frame_done) frames++;
            stop = (frame_done && frames == 3);
        end
        stop = 1'b0;
        if (busy) check_output("d_timeout", int'(busy), 0);
        sample_valid = 1'b0;
        check_output("d_frames_left", exp_q.size(), 0);

        // Start and stop together: exactly one frame of the waiting sample.
        exp_q = {base + 4};
        pulse_start(1'b1);
        wait_idle(2 * N);
        tick();
        check_output("e_frames_left", exp_q.size(), 0);
        stop = 1'b1;
        repeat (5) tick();
        stop = 1'b0;
        check_output("e_stop_in_idle", int'(busy), 0);

        // Asynchronous reset mid-frame with a one on the output and the holding register full.
        frame_check_en = 0;
        push_sample(8'hC0);
        pulse_start(1'b0);
        push_sample(8'h80);
        n = 0;
        while (!dac_out && n < 20) begin
            tick();
            n++;
        end
        check_output("f_pre_dac", int'(dac_out), 1);
        check_output("f_pre_ready", int'(sample_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("f_rst_dac", int'(dac_out), 0);
        check_output("f_rst_busy", int'(busy), 0);
        check_output("f_rst_ready", int'(sample_ready), 1);
        check_output("f_rst_fd", int'(frame_done), 0);
        check_output("f_rst_ur", int'(underrun), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            sample_valid = ($urandom_range(0, 3) == 0);
            sample_in    = WIDTH'($urandom);
            start        = ($urandom_range(0, 49) == 0);
            stop         = ($urandom_range(0, 699) == 0);
            tick();
        end
        sample_valid = 1'b0;
        start = 1'b0;
        stop_one_cycle();
        wait_idle(2 * N);
    endtask

    initial begin
        for (int i = 0; i < N; i++) hist[i] = 0;
        apply_stimulus();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/sigma_delta_dac.md
# sigma_delta_dac

First-order sigma-delta DAC: the output-direction counterpart of the team's 8-bit accumulating ADC. It accepts WIDTH-bit samples over a valid/ready handshake and double-buffers them. Each sample plays out as a frame of 2^WIDTH one-bit pulses on `dac_out` whose ones-count equals the sample value. The block sits between the digital datapath and an external RC filter or pin driver.

## Interface
- WIDTH, 8, sample width; frame length is 2^WIDTH clock cycles.

- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  level-sampled; begins conversion when in IDLE, ignored in RUN.
- stop  input  1  level-sampled; requests a stop at the end of the current frame.
- sample_in  input  WIDTH  next sample value.
- sample_valid  input  1  sample_in is valid.
- sample_ready  output  1  holding register empty; a transfer occurs on an edge where valid && ready.
- dac_out  output  1  registered pulse-density output.
- busy  output  1  high in RUN.
- frame_done  output  1  one-cycle pulse after each frame's last bit edge.
- underrun  output  1  one-cycle pulse when a frame loads with no sample pending.

## Operation
- State: IDLE, RUN.
- Internal registers:
  - hold[WIDTH-1:0] and hold_full;
  - cur[WIDTH-1:0], the playing sample;
  - acc[WIDTH-1:0];
  - count[WIDTH-1:0];
  - stop_pending.
- sample_ready = !hold_full (combinational from the register).
  - A transfer sets hold_full and captures sample_in.
  - A load clears hold_full, except that a load and an accept cannot coincide, because ready=0 when hold_full=1.
- IDLE:
  - dac_out<=0, acc<=0, count<=0, stop_pending<=0.
  - On start=1 the state moves to RUN and a load is performed.
- Load:
  - If hold_full, cur<=hold and hold_full<=0.
  - Else cur<=0 and underrun pulses.
- RUN, every edge:
  - {carry, acc} <= acc + cur, a WIDTH+1-bit sum; the accumulator wraps modulo 2^WIDTH.
  - dac_out<=carry.
  - count<=count+1.
  - If stop=1, stop_pending<=1.
- RUN edge with count==2^WIDTH-1 (frame boundary):
  - The last bit is computed with the old cur.
  - count wraps to 0 and frame_done pulses.
  - If stop_pending or stop is set, the state moves to IDLE with no load.
  - Otherwise a load occurs on the same edge and the state stays in RUN.
  - acc is NOT cleared at the boundary. Residue carries over, and the per-frame ones-count still equals cur exactly.
- A start arriving in RUN is ignored. stop in IDLE has no effect. If start and stop are both set in IDLE, the block enters RUN with stop_pending=1, so exactly one frame plays.

## Timing
- Reset values: state IDLE, dac_out=0, busy=0, frame_done=0, underrun=0, sample_ready=1, hold_full=0, cur=0, acc=0, count=0.
- rst_n low mid-frame forces all of these immediately, without waiting for a clock edge.
- Start sampled at edge E0:
  - busy=1 after E0.
  - The bit for frame cycle k is produced at edge E(k+1) and is visible for one cycle.
  - A frame is 2^WIDTH consecutive dac_out cycles.
- frame_done and underrun are high for exactly one cycle after the edge that causes them.
- On the stop exit edge:
  - busy falls after the same edge at which frame_done rises.
  - The last bit stays visible for that one cycle.
  - dac_out=0 thereafter.
- A sample accepted at any point before a boundary edge plays in the next frame.
- sample_ready returns to 1 the cycle after the load edge.

## Test plan
- Reset mid-frame with dac_out=1 and hold_full=1 -> all outputs reach reset values before the next clk edge; sample_ready=1.
- Push 0x40, pulse start -> underrun=0; the first 256 dac_out cycles contain exactly 64 ones, one every 4 cycles; frame_done pulses after the 256th RUN edge.
- Push 0x00, then 0xFF at the next ready -> frame 1 is all zeros; frame 2 has 255 ones and a single zero; sample_ready=0 while 0xFF waits.
- Start with the holding register empty -> underrun pulses once; the frame is all zeros.
  - Pushing 0x80 mid-frame makes the next frame contain 128 ones, with no underrun.
- Hold sample_valid=1 continuously with increasing values -> exactly one sample is accepted per frame; ready is low from accept until the next boundary load; no samples are lost or duplicated.
- Assert stop at frame cycle 10 -> the frame completes all 256 bits; frame_done=1 and busy=0 in the same cycle; dac_out=0 afterwards; a new start restarts with acc=0.
